// File: rtl/instr_router.sv
// Three-way instruction router: one valid/ready input steered to self/left/right FIFOs,
// each with its own valid/ready output. Broadcast (dest 11) writes all three atomically.
module instr_router #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_dest,
    input  logic [WIDTH-1:0] in_instr,
    output logic             self_valid,
    input  logic             self_ready,
    output logic [WIDTH-1:0] self_instr,
    output logic             left_valid,
    input  logic             left_ready,
    output logic [WIDTH-1:0] left_instr,
    output logic             right_valid,
    input  logic             right_ready,
    output logic [WIDTH-1:0] right_instr,
    output logic [CNT_W-1:0] self_count,
    output logic [CNT_W-1:0] left_count,
    output logic [CNT_W-1:0] right_count
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned NCH      = 3;
    localparam int unsigned CH_SELF  = 0;
    localparam int unsigned CH_LEFT  = 1;
    localparam int unsigned CH_RIGHT = 2;

    logic             run_q;
    logic [NCH-1:0]   target;
    logic [NCH-1:0]   not_full;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [NCH-1:0]   ch_ready;
    logic [NCH-1:0]   ch_valid;
    logic [WIDTH-1:0] ch_instr [NCH];
    logic [CNT_W-1:0] ch_count [NCH];

    // Holds in_ready low through reset and for the cycle up to the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    always_comb begin
        target = '0;
        case (in_dest)
            2'b00:   target[CH_SELF]  = 1'b1;
            2'b01:   target[CH_RIGHT] = 1'b1;
            2'b10:   target[CH_LEFT]  = 1'b1;
            default: target           = '1;
        endcase
    end

    // Every targeted FIFO must have room; uses registered counts only, so no pop-through.
    always_comb begin
        in_ready = 1'b0;
        if (run_q) in_ready = &(not_full | ~target);
    end

    assign push     = {NCH{in_valid & in_ready}} & target;
    assign ch_ready = {right_ready, left_ready, self_ready};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    rd_q;
        logic [AW-1:0]    wr_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_n;
        logic [CNT_W-1:0] remain;
        logic [WIDTH-1:0] head_q;
        logic [WIDTH-1:0] head_n;

        assign pop[i]      = (cnt_q != '0) & ch_ready[i];
        assign not_full[i] = cnt_q < CNT_W'(DEPTH);
        assign ch_valid[i] = cnt_q != '0;
        assign ch_instr[i] = head_q;
        assign ch_count[i] = cnt_q;

        // Next head: next stored entry if one survives the pop, else the incoming word, else hold.
        always_comb begin
            remain = cnt_q - CNT_W'(pop[i]);
            cnt_n  = remain + CNT_W'(push[i]);
            head_n = head_q;
            if (remain != '0)  head_n = mem[rd_q + AW'(pop[i])];
            else if (push[i])  head_n = in_instr;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q   <= '0;
                wr_q   <= '0;
                cnt_q  <= '0;
                head_q <= '0;
            end else begin
                cnt_q  <= cnt_n;
                head_q <= head_n;
                if (pop[i])  rd_q <= rd_q + AW'(1);
                if (push[i]) wr_q <= wr_q + AW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_q] <= in_instr;
        end
    end

    assign self_valid  = ch_valid[CH_SELF];
    assign left_valid  = ch_valid[CH_LEFT];
    assign right_valid = ch_valid[CH_RIGHT];
    assign self_instr  = ch_instr[CH_SELF];
    assign left_instr  = ch_instr[CH_LEFT];
    assign right_instr = ch_instr[CH_RIGHT];
    assign self_count  = ch_count[CH_SELF];
    assign left_count  = ch_count[CH_LEFT];
    assign right_count = ch_count[CH_RIGHT];

endmodule

// File: tb/tb_instr_router.sv
// Directed bench for instr_router: unicast, backpressure, broadcast, wrap, full push+pop, async reset.
module tb_instr_router;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_dest;
    logic [WIDTH-1:0] in_instr;
    logic             self_valid, left_valid, right_valid;
    logic             self_ready, left_ready, right_ready;
    logic [WIDTH-1:0] self_instr, left_instr, right_instr;
    logic [CNT_W-1:0] self_count, left_count, right_count;

    int n_checks = 0;
    int n_errors = 0;

    instr_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dest     (in_dest),
        .in_instr    (in_instr),
        .self_valid  (self_valid),
        .self_ready  (self_ready),
        .self_instr  (self_instr),
        .left_valid  (left_valid),
        .left_ready  (left_ready),
        .left_instr  (left_instr),
        .right_valid (right_valid),
        .right_ready (right_ready),
        .right_instr (right_instr),
        .self_count  (self_count),
        .left_count  (left_count),
        .right_count (right_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [1:0] d, input logic [31:0] w);
        in_valid = 1'b1;
        in_dest  = d;
        in_instr = w;
        #1;
        chk("push_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_dest = 2'b00; in_instr = '0;
        self_ready = 1'b0; left_ready = 1'b0; right_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_self_valid", 32'(self_valid), 32'd0);
        chk("rst_left_valid", 32'(left_valid), 32'd0);
        chk("rst_right_valid", 32'(right_valid), 32'd0);
        chk("rst_self_instr", self_instr, 32'd0);
        chk("rst_left_count", 32'(left_count), 32'd0);
        #6 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready_post_edge", 32'(in_ready), 32'd1);

        // T1 unicast
        push_word(2'b00, 32'hA5A5_0001);
        chk("t1_self_valid", 32'(self_valid), 32'd1);
        chk("t1_self_instr", self_instr, 32'hA5A5_0001);
        chk("t1_self_count", 32'(self_count), 32'd1);
        chk("t1_left_valid", 32'(left_valid), 32'd0);
        chk("t1_right_valid", 32'(right_valid), 32'd0);
        self_ready = 1'b1;
        tick();
        self_ready = 1'b0;
        chk("t1_self_empty", 32'(self_valid), 32'd0);
        chk("t1_self_hold", self_instr, 32'hA5A5_0001);

        // T2 backpressure on right
        for (int k = 1; k <= 4; k++) push_word(2'b01, 32'(k));
        chk("t2_right_count", 32'(right_count), 32'd4);
        in_dest = 2'b01; #1;
        chk("t2_ready_right_full", 32'(in_ready), 32'd0);
        in_dest = 2'b00; #1;
        chk("t2_ready_self", 32'(in_ready), 32'd1);
        right_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_drain_valid", 32'(right_valid), 32'd1);
            chk("t2_drain_order", right_instr, 32'(k));
            tick();
        end
        right_ready = 1'b0;
        chk("t2_right_empty", 32'(right_valid), 32'd0);

        // T3 broadcast
        push_word(2'b11, 32'hDEAD_BEEF);
        chk("t3_self_instr", self_instr, 32'hDEAD_BEEF);
        chk("t3_left_instr", left_instr, 32'hDEAD_BEEF);
        chk("t3_right_instr", right_instr, 32'hDEAD_BEEF);
        chk("t3_valids", 32'({self_valid, left_valid, right_valid}), 32'h7);
        chk("t3_counts", 32'({self_count, left_count, right_count}), {23'd0, 9'b001_001_001});
        self_ready = 1'b1; left_ready = 1'b1; right_ready = 1'b1;
        tick();
        self_ready = 1'b0; left_ready = 1'b0; right_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_word(2'b10, 32'h10 + 32'(k));
        in_valid = 1'b1; in_dest = 2'b11; in_instr = 32'hBAD0_0000; #1;
        chk("t3_bcast_blocked", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("t3_no_self_write", 32'(self_count), 32'd0);
        chk("t3_no_right_write", 32'(right_count), 32'd0);
        chk("t3_left_still_full", 32'(left_count), 32'd4);

        // T5 full FIFO with simultaneous pop
        left_ready = 1'b1;
        in_valid = 1'b1; in_dest = 2'b10; in_instr = 32'h20; #1;
        chk("t5_full_no_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t5_count_dec", 32'(left_count), 32'd3);
        chk("t5_head_after_pop", left_instr, 32'h11);
        chk("t5_ready_next", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t5_count_steady", 32'(left_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_w;
            exp_w = (k == 2) ? 32'h20 : 32'h12 + 32'(k);
            chk("t5_drain_order", left_instr, exp_w);
            tick();
        end
        chk("t5_left_empty", 32'(left_valid), 32'd0);

        // T4 streaming through left with wrap
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_dest = 2'b10; in_instr = 32'h100 + 32'(k); #1;
            chk("t4_ready", 32'(in_ready), 32'd1);
            tick();
            chk("t4_valid", 32'(left_valid), 32'd1);
            chk("t4_order", left_instr, 32'h100 + 32'(k));
            chk("t4_count", 32'(left_count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        left_ready = 1'b0;
        chk("t4_final_empty", 32'(left_count), 32'd0);
        chk("t4_final_hold", left_instr, 32'h109);

        // T6 async reset mid-stream
        push_word(2'b00, 32'h600);
        push_word(2'b00, 32'h601);
        chk("t6_pre_count", 32'(self_count), 32'd2);
        in_valid = 1'b1; in_dest = 2'b00; in_instr = 32'h602;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_self_valid", 32'(self_valid), 32'd0);
        chk("t6_self_count", 32'(self_count), 32'd0);
        chk("t6_self_instr", self_instr, 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        #1 rst_n = 1'b1;
        tick();
        chk("t6_ready_after_rel", 32'(in_ready), 32'd1);
        chk("t6_still_empty", 32'(self_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
